// File: rtl/edge_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_mon_pkg
// Purpose  : Shared FSM state encoding and default counter width for the
//            edge event monitor.
// Revision : 1.0 - initial release
// ============================================================================
package edge_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } mon_state_e;

    localparam int DEFAULT_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones; clear wins over increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
    import edge_mon_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = &count_q;

endmodule
`default_nettype wire

// File: rtl/edge_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_monitor
// Purpose  : Registered edge detector with sample history, IDLE/PRIME/RUN
//            gating and saturating rise / no-rise event counters.
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_monitor
    import edge_mon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             en,
    input  logic             clr,
    output logic             rose_o,
    output logic             fell_o,
    output logic             stable_o,
    output logic [DEPTH-1:0] past_o,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             sat_o
);

    mon_state_e       state_q;
    mon_state_e       state_d;
    logic             a_q;
    logic             a_d;
    logic [DEPTH-1:0] past_q;
    logic [DEPTH-1:0] past_d;
    logic             sat_q;
    logic             sat_d;

    logic             w_run;
    logic             w_rise_inc;
    logic             w_miss_inc;
    logic             w_rise_at_max;
    logic             w_miss_at_max;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = PRIME;
            PRIME:   if (en) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
        end
    end

    // History runs in every state so the reference sample is ready on entry to RUN.
    always_comb begin
        a_d    = a_in;
        past_d = {past_q[DEPTH-2:0], a_q};
    end

    always_comb begin
        w_run      = (state_q == RUN);
        rose_o     = w_run &  a_q & ~past_q[0];
        fell_o     = w_run & ~a_q &  past_q[0];
        stable_o   = w_run & ~(rose_o | fell_o);
        w_rise_inc = rose_o;
        w_miss_inc = w_run & ~rose_o;
    end

    // Counter all-ones is reflected at once; sat_q keeps it after the counter is cleared only by clr.
    always_comb begin
        sat_d = clr ? 1'b0 : (sat_q | w_rise_at_max | w_miss_at_max);
        sat_o = sat_q | w_rise_at_max | w_miss_at_max;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
            past_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            past_q  <= past_d;
            sat_q   <= sat_d;
        end
    end

    assign past_o = past_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_rise_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_rise_inc),
        .clr    (clr),
        .count  (rise_cnt),
        .at_max (w_rise_at_max)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_miss_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_miss_inc),
        .clr    (clr),
        .count  (miss_cnt),
        .at_max (w_miss_at_max)
    );

endmodule
`default_nettype wire

// File: tb/tb_edge_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_monitor
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random traffic against a sample-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_monitor;

    localparam int DP   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_in = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          rose_o;
    logic          fell_o;
    logic          stable_o;
    logic [DP-1:0] past_o;
    logic [CW-1:0] rise_cnt;
    logic [CW-1:0] miss_cnt;
    logic          sat_o;

    int n_cmp  = 0;
    int n_fail = 0;

    edge_event_monitor #(
        .DEPTH (DP),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .en       (en),
        .clr      (clr),
        .rose_o   (rose_o),
        .fell_o   (fell_o),
        .stable_o (stable_o),
        .past_o   (past_o),
        .rise_cnt (rise_cnt),
        .miss_cnt (miss_cnt),
        .sat_o    (sat_o)
    );

    always #5 clk = ~clk;

    // Reference model: samples[0] is the newest captured value, samples[k] the one k clocks older.
    logic m_samples [0:DP];
    int   m_en_run;
    int   m_rc;
    int   m_mc;
    logic m_sat;

    function automatic logic m_active();
        return m_en_run >= 2;
    endfunction

    function automatic logic m_rose();
        return m_active() && m_samples[0] && !m_samples[1];
    endfunction

    function automatic logic m_fell();
        return m_active() && !m_samples[0] && m_samples[1];
    endfunction

    function automatic logic [DP-1:0] m_past();
        logic [DP-1:0] p;
        for (int k = 0; k < DP; k++) p[k] = m_samples[k+1];
        return p;
    endfunction

    task automatic model_update(input logic r, input logic e, input logic c, input logic a);
        logic act;
        logic rs;
        if (r) begin
            for (int k = 0; k <= DP; k++) m_samples[k] = 1'b0;
            m_en_run = 0;
            m_rc     = 0;
            m_mc     = 0;
            m_sat    = 1'b0;
        end else begin
            act = m_active();
            rs  = m_rose();
            if (c) begin
                m_rc  = 0;
                m_mc  = 0;
                m_sat = 1'b0;
            end else if (act) begin
                if (rs) m_rc = (m_rc < MAXC) ? m_rc + 1 : m_rc;
                else    m_mc = (m_mc < MAXC) ? m_mc + 1 : m_mc;
                if (m_rc == MAXC || m_mc == MAXC) m_sat = 1'b1;
            end
            for (int k = DP; k > 0; k--) m_samples[k] = m_samples[k-1];
            m_samples[0] = a;
            m_en_run = e ? ((m_en_run < 2) ? m_en_run + 1 : 2) : 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_rose",   rose_o,   m_rose());
        chk("model_fell",   fell_o,   m_fell());
        chk("model_stable", stable_o, m_active() && !m_rose() && !m_fell());
        chk("model_past",   past_o,   m_past());
        chk("model_rise",   rise_cnt, m_rc);
        chk("model_miss",   miss_cnt, m_mc);
        chk("model_sat",    sat_o,    m_sat);
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic a);
        @(negedge clk);
        rst  = r;
        en   = e;
        clr  = c;
        a_in = a;
        @(posedge clk);
        #1;
        model_update(r, e, c, a);
        compare_model();
    endtask

    typedef struct {
        logic          rst;
        logic          en;
        logic          clr;
        logic          a;
        logic          rose;
        logic          fell;
        logic          stable;
        logic [DP-1:0] past;
        int            rc;
        int            mc;
        logic          sat;
    } vec_t;

    vec_t tbl [9];

    initial begin
        for (int k = 0; k <= DP; k++) m_samples[k] = 1'b0;
        m_en_run = 0;
        m_rc     = 0;
        m_mc     = 0;
        m_sat    = 1'b0;

        // Reset, then a_in 0,1,1,0,1,1 with en high, then en dropped.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 0, 0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1, 0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 1, 1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 1, 2, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1101, 2, 2, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 2, 3, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 2, 3, 1'b0};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].a);
            chk("tbl_rose",   rose_o,   tbl[i].rose);
            chk("tbl_fell",   fell_o,   tbl[i].fell);
            chk("tbl_stable", stable_o, tbl[i].stable);
            chk("tbl_past",   past_o,   tbl[i].past);
            chk("tbl_rise",   rise_cnt, tbl[i].rc);
            chk("tbl_miss",   miss_cnt, tbl[i].mc);
            chk("tbl_sat",    sat_o,    tbl[i].sat);
        end

        // a_in held high through PRIME into RUN.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("held_prime_stable", stable_o, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            chk("held_rose",   rose_o,   1'b0);
            chk("held_stable", stable_o, 1'b1);
            chk("held_miss",   miss_cnt, i);
        end

        // clr on the same edge that would count a rise.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_pre_rose", rose_o, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_rise", rise_cnt, 0);
        chk("clr_miss", miss_cnt, 0);

        // Saturation with a toggling input.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, i[0]);
        chk("sat_rise", rise_cnt, MAXC);
        chk("sat_miss", miss_cnt, MAXC);
        chk("sat_flag", sat_o, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, i[0]);
        chk("sat_hold_rise", rise_cnt, MAXC);
        chk("sat_hold_flag", sat_o, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat_clr_flag", sat_o, 1'b0);
        chk("sat_clr_rise", rise_cnt, 0);

        // Reset mid-RUN coinciding with a 0->1 input.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_pre_stable", stable_o, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_rose",   rose_o,   1'b0);
        chk("rst_mid_stable", stable_o, 1'b0);
        chk("rst_mid_miss",   miss_cnt, 0);
        chk("rst_mid_past",   past_o,   0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_prime_rose",   rose_o,   1'b0);
        chk("rst_prime_stable", stable_o, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_run_rose",   rose_o,   1'b0);
        chk("rst_run_stable", stable_o, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
